// File: rtl/csa_pkg.sv
// Shared types and defaults for the carry-save resolver.
// Holds the FSM state encoding and the default operand/chunk widths.
package csa_pkg;

  localparam int CSA_W     = 8;
  localparam int CSA_CHUNK = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_adder.sv
// Narrow ripple adder with carry in/out.
// One instance is time-shared across all chunks of an operand.
module chunk_adder #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[N];
  end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save pair into binary, CHUNK bits per cycle.
// Operands shift right each cycle so the adder always sees the low chunk.
module csa_resolver
  import csa_pkg::*;
#(
  parameter int W     = CSA_W,
  parameter int CHUNK = CSA_CHUNK
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   result,
  output logic         busy
);

  localparam int NCH = W / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK < 1 || (W % CHUNK) != 0) begin : g_chk
    $fatal(1, "csa_resolver: W must be a multiple of CHUNK");
  end

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    lo_q;
  logic            msb_q;
  logic [CW-1:0]   cnt;
  logic            cy;

  logic [CHUNK-1:0]   s;
  logic               co;
  logic               last;
  logic [W+CHUNK-1:0] lo_next;

  chunk_adder #(.N(CHUNK)) u_add (
    .a  (a_q[CHUNK-1:0]),
    .b  (b_q[CHUNK-1:0]),
    .ci (cy),
    .s  (s),
    .co (co)
  );

  // New sum enters at the top; after NCH shifts chunk k sits at k*CHUNK.
  assign lo_next = {s, lo_q};
  assign last    = (cnt == CW'(NCH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      lo_q  <= '0;
      msb_q <= 1'b0;
      cnt   <= '0;
      cy    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= sum_in;
            b_q   <= carry_in;
            cnt   <= '0;
            cy    <= 1'b0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_q  <= a_q >> CHUNK;
          b_q  <= b_q >> CHUNK;
          lo_q <= lo_next[W+CHUNK-1:CHUNK];
          cy   <= co;
          cnt  <= cnt + CW'(1);
          if (last) begin
            msb_q <= co;
            cnt   <= '0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = !reset && (state == S_IDLE);
  assign out_valid = !reset && (state == S_DONE);
  assign busy      = !reset && (state != S_IDLE);
  assign result    = {msb_q, lo_q};

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver (W=8, CHUNK=2).
// Expected results come from plain integer addition of the pair.
module tb_csa_resolver;

  localparam int W   = 8;
  localparam int LAT = 4;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] sum_in;
  logic [W-1:0] carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic         busy;

  int n_cmp;
  int n_bad;

  csa_resolver #(.W(W), .CHUNK(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W:0] model(input int a, input int b);
    int r;
    r = a + b;
    return r[W:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair when the block is ready; returns after the accept edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    sum_in   = a;
    carry_in = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    ok = (n < 20);
  endtask

  // Edges from the accept edge until out_valid is seen (-1 on timeout).
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_state: rdy/ov/busy=%b result=%h want 000/000",
               {in_ready, out_valid, busy}, result);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b busy=%b want 1/0",
               in_ready, busy);
    end
  endtask

  task automatic run_one(input string nm, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    bit ok;
    int lat;
    logic [W:0] exp;
    exp = model(int'(a), int'(b));
    out_ready = 1'b1;
    accept(a, b, ok);
    n_cmp++;
    if (!ok || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_accept: ok=%0d busy=%b in_ready=%b want 1/1/0",
               nm, ok, busy, in_ready);
    end
    wait_out(lat);
    n_cmp++;
    if (lat != LAT || result !== exp) begin
      n_bad++;
      $display("FAIL %s: latency=%0d result=%h want %0d/%h",
               nm, lat, result, LAT, exp);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b want 0/1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    run_one("alt_bits", 8'h55, 8'hAA);
    run_one("full_ripple", 8'hFF, 8'hFF);
  endtask

  task automatic test_back_to_back();
    int n;
    int lat;
    bit got1;
    logic [W:0] r1;
    out_ready = 1'b1;
    while (!in_ready) step();
    sum_in   = 8'h34;
    carry_in = 8'h00;
    in_valid = 1'b1;
    step();
    sum_in   = 8'h00;
    carry_in = 8'h00;
    n = 0;
    got1 = 1'b0;
    r1 = '0;
    do begin
      step();
      n++;
      if (out_valid && !got1) begin
        got1 = 1'b1;
        r1   = result;
      end
    end while (!in_ready && n < 20);
    step();
    n++;
    in_valid = 1'b0;
    n_cmp++;
    if (!got1 || r1 !== 9'h034) begin
      n_bad++;
      $display("FAIL b2b_first: seen=%0d result=%h want 1/034", got1, r1);
    end
    n_cmp++;
    if (n != LAT + 2) begin
      n_bad++;
      $display("FAIL b2b_interval: interval=%0d want %0d", n, LAT + 2);
    end
    wait_out(lat);
    n_cmp++;
    if (lat != LAT || result !== 9'h000) begin
      n_bad++;
      $display("FAIL b2b_second: latency=%0d result=%h want %0d/000",
               lat, result, LAT);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int bad;
    out_ready = 1'b0;
    accept(8'h3C, 8'h1C, ok);
    wait_out(lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== 9'h058) bad++;
      step();
    end
    n_cmp++;
    if (!ok || lat != LAT || bad != 0) begin
      n_bad++;
      $display("FAIL backpressure_hold: ok=%0d lat=%0d unstable=%0d want 1/%0d/0",
               ok, lat, bad, LAT);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL backpressure_release: out_valid=%b busy=%b want 0/0",
               out_valid, busy);
    end
  endtask

  task automatic test_ignore_in_run();
    bit ok;
    int lat;
    int rdy_hi;
    out_ready = 1'b1;
    accept(8'h12, 8'h34, ok);
    sum_in   = 8'hF0;
    carry_in = 8'h0F;
    in_valid = 1'b1;
    rdy_hi = 0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0) rdy_hi++;
      step();
    end
    in_valid = 1'b0;
    wait_out(lat);
    n_cmp++;
    if (!ok || rdy_hi != 0) begin
      n_bad++;
      $display("FAIL run_in_ready: ok=%0d ready_cycles=%0d want 1/0",
               ok, rdy_hi);
    end
    n_cmp++;
    if (lat != 1 || result !== 9'h046) begin
      n_bad++;
      $display("FAIL run_ignore: lat=%0d result=%h want 1/046", lat, result);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int lat;
    out_ready = 1'b1;
    accept(8'hAB, 8'hCD, ok);
    step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({in_ready, out_valid, busy} !== 3'b000 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_run: rdy/ov/busy=%b result=%h want 000/000",
               {in_ready, out_valid, busy}, result);
    end
    reset = 1'b0;
    #1;
    run_one("after_reset", 8'h01, 8'h01);
  endtask

  task automatic test_random();
    bit ok;
    int lat;
    int d;
    int bad;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0] exp;
    for (int k = 0; k < 24; k++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      exp = model(int'(a), int'(b));
      d   = $urandom_range(0, 3);
      out_ready = 1'b0;
      accept(a, b, ok);
      wait_out(lat);
      n_cmp++;
      if (!ok || lat != LAT || result !== exp) begin
        n_bad++;
        $display("FAIL random_%0d: %h+%h lat=%0d result=%h want %0d/%h",
                 k, a, b, lat, result, LAT, exp);
      end
      bad = 0;
      for (int i = 0; i < d; i++) begin
        step();
        if (out_valid !== 1'b1 || result !== exp) bad++;
      end
      out_ready = 1'b1;
      step();
      n_cmp++;
      if (bad != 0 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL random_hold_%0d: unstable=%0d out_valid=%b want 0/0",
                 k, bad, out_valid);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    carry_in  = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_ignore_in_run();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csa_resolver.md
CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 Parameter W, default 8: width of each redundant operand vector.
REQ-002 Parameter CHUNK, default 2: bits resolved per cycle; W SHALL be an integer multiple of CHUNK (elaboration-time check, fatal on violation).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  sum_in/carry_in hold a valid carry-save pair.
REQ-006 in_ready  output  1  block can accept a pair this cycle.
REQ-007 sum_in  input  W  carry-save sum vector; bit i has weight 2^i.
REQ-008 carry_in  input  W  carry-save carry vector, pre-aligned; bit i has weight 2^i.
REQ-009 out_valid  output  1  result holds the resolved binary value.
REQ-010 out_ready  input  1  downstream accepts result this cycle.
REQ-011 result  output  W+1  binary value, sum_in + carry_in, unsigned.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch both vectors, clear the chunk counter and the internal carry, and go to RUN.
REQ-015 RUN: each cycle, add chunk k of both latched vectors plus the internal carry; write the CHUNK-bit sum into result bits [k*CHUNK +: CHUNK]; store carry-out; increment k.
REQ-016 RUN SHALL last exactly W/CHUNK cycles; on the last chunk, write the carry-out into result[W] and go to DONE.
REQ-017 Latency: out_valid SHALL rise W/CHUNK clock edges after the accepting edge (4 for the defaults).
REQ-018 DONE: out_valid=1; result SHALL hold stable until out_valid&&out_ready; then go to IDLE on that edge.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid in those states is ignored and not queued.
REQ-020 out_ready outside DONE SHALL have no effect.
REQ-021 Minimum initiation interval: W/CHUNK+2 cycles with out_ready held high.
REQ-022 result bits not yet written during RUN are don't-care; only the value qualified by out_valid is defined.
REQ-023 Arithmetic: unsigned, no overflow possible; result[W] is the final carry.

Reset
REQ-024 While reset is high: state=IDLE, out_valid=0, in_ready=0, busy=0, result=0, counter=0, internal carry=0.
REQ-025 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-026 Reset asserted in RUN or DONE SHALL abandon the operation with no output handshake; the next accepted pair is resolved from scratch.

Structure
REQ-027 Shared package csa_pkg SHALL hold the FSM state enum and the default W and CHUNK constants.
REQ-028 Sub-module chunk_adder SHALL implement a CHUNK-bit ripple adder with carry-in and carry-out; it is instantiated once and reused every RUN cycle.
REQ-029 The datapath SHALL be a single adder plus operand, result, and counter registers; there SHALL be no full-width adder.

Verification (W=8, CHUNK=2)
REQ-030 sum_in=0x55, carry_in=0xAA, out_ready=1 -> result=0x0FF, out_valid rises 4 edges after accept, held 1 cycle.
REQ-031 sum_in=0xFF, carry_in=0xFF -> result=0x1FE (full carry ripple across all chunks).
REQ-032 sum_in=0x34, carry_in=0x00, then 0x00/0x00 back-to-back -> results 0x034, then 0x000; second pair accepted only after the IDLE return (interval 6 cycles).
REQ-033 Backpressure: sum_in=0x3C, carry_in=0x1C, out_ready low for 10 cycles -> out_valid high and result=0x058 stable for all 10; one handshake on release.
REQ-034 in_valid held high with a new pair during RUN -> in_ready=0, pair not captured, first result unaffected.
REQ-035 Reset asserted in the 2nd RUN cycle -> next cycle all outputs are at reset values; a following pair 0x01/0x01 yields 0x002.
